// File: rtl/dmem_bus_arbiter_pkg.sv
// rtl/dmem_bus_arbiter_pkg.sv - shared types and defaults for the data-bus arbiter
package dmem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    // Address bit that steers the bus to peripheral space instead of Data_Mem
    localparam int PERIPH_SEL_BIT = 30;

endpackage

// File: rtl/dmem_bus_arbiter_if.sv
// rtl/dmem_bus_arbiter_if.sv - CPU, loader and memory-side signals of the arbiter
interface dmem_bus_arbiter_if
    import dmem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              ld_req;
    logic              ld_wr;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_done;
    logic [DATA_W-1:0] ld_rdata;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  ld_req, ld_wr, ld_addr, ld_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall,
        output ld_gnt, ld_done, ld_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output ld_req, ld_wr, ld_addr, ld_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  ld_gnt, ld_done, ld_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_bus_arbiter_arb_wait_timer.sv
// rtl/dmem_bus_arbiter_arb_wait_timer.sv - loader wait counter with terminal count
module arb_wait_timer #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [WAIT_W-1:0] TC_VAL = (MAX_WAIT > 0) ? WAIT_W'(MAX_WAIT - 1) : '0;

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/dmem_bus_arbiter.sv
// rtl/dmem_bus_arbiter.sv - CPU/loader data-bus arbiter with bounded loader wait
// Optional ARB_STATS_EN adds saturating transfer and stall counters.
module dmem_bus_arbiter
    import dmem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_bus_arbiter_if.slave     bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]           stat_xfer,
    output logic [15:0]           stat_stall
`endif
);

    arb_state_e        state_q, state_d;
    logic              cpu_busy;
    logic              xfer;
    logic              wait_tc;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic [DATA_W-1:0] ld_rdata_q;

    assign cpu_busy = bus.cpu_rd | bus.cpu_wr;
    assign xfer     = (state_q == ST_XFER);

    arb_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_d != ST_WAIT),
        .en_i    (state_q == ST_WAIT),
        .tc_o    (wait_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ld_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (xfer && !bus.ld_wr) begin
                ld_rdata_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.ld_gnt    = 1'b0;
        bus.ld_done   = 1'b0;
        bus.cpu_stall = 1'b0;
        bus.mem_rd    = bus.cpu_rd;
        bus.mem_wr    = bus.cpu_wr;
        addr_sel      = bus.cpu_addr;
        wdata_sel     = bus.cpu_wdata;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.ld_req) begin
                    state_d = (!cpu_busy || MAX_WAIT == 0) ? ST_XFER : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.ld_req) begin
                    state_d = ST_IDLE;
                end else if (!cpu_busy || wait_tc) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                bus.ld_gnt    = 1'b1;
                bus.cpu_stall = cpu_busy;
                bus.mem_rd    = ~bus.ld_wr;
                // A loader write must not land on the edge that resets us
                bus.mem_wr    = bus.ld_wr & reset;
                addr_sel      = bus.ld_addr;
                wdata_sel     = bus.ld_wdata;
                state_d       = ST_DONE;
            end
            ST_DONE: begin
                bus.ld_done = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.ld_rdata  = ld_rdata_q;

`ifdef ARB_STATS_EN
    logic [15:0] stat_xfer_q, stat_stall_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_xfer_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            if (xfer && stat_xfer_q != 16'hFFFF) begin
                stat_xfer_q <= stat_xfer_q + 16'd1;
            end
            if (bus.cpu_stall && stat_stall_q != 16'hFFFF) begin
                stat_stall_q <= stat_stall_q + 16'd1;
            end
        end
    end

    assign stat_xfer  = stat_xfer_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb/tb_dmem_bus_arbiter.sv - randomized self-checking bench for dmem_bus_arbiter
module tb_dmem_bus_arbiter;
    import dmem_bus_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 8;
    localparam int WW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef ARB_STATS_EN
    logic [15:0] stat_xfer, stat_stall;
`endif

    dmem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .WAIT_W(WW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef ARB_STATS_EN
        ,
        .stat_xfer  (stat_xfer),
        .stat_stall (stat_stall)
`endif
    );

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    int total = 0;
    int bad = 0;

    logic        pat_rd [16];
    logic        pat_wr [16];
    logic [31:0] pat_addr [16];
    logic [31:0] pat_wdata [16];

    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
    always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

    task automatic fill_pattern(input int pct);
        for (int i = 0; i < 16; i++) begin
            logic busy, rd;
            logic [7:0] w;
            busy = ($urandom_range(99) < pct);
            rd   = 1'($urandom_range(1));
            pat_rd[i] = busy & rd;
            pat_wr[i] = busy & ~rd;
            w = pat_wr[i] ? 8'(64 + $urandom_range(63)) : 8'($urandom_range(255));
            pat_addr[i]  = 32'(w) << 2;
            pat_wdata[i] = $urandom;
        end
    endtask

    task automatic drive_cpu(input int i);
        bus.cpu_rd    = pat_rd[i];
        bus.cpu_wr    = pat_wr[i];
        bus.cpu_addr  = pat_addr[i];
        bus.cpu_wdata = pat_wdata[i];
    endtask

    task automatic drive_idle();
        bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ld_req = 1'b0; bus.ld_wr = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
    endtask

    // One loader request against the CPU pattern; the expected grant cycle is derived
    // from the priority/bounded-wait rules, then every cycle is compared.
    task automatic run_transfer(input logic wr, input logic [7:0] word,
                                input logic [31:0] wdata, input int drop_at);
        logic [31:0] la, exp_rdata, ea, ewd;
        int x, endc, last, pi, nbad;
        bit abort;
        logic eg, ed, es, erd, ewr;
        la = 32'(word) << 2;
        la[PERIPH_SEL_BIT] = 1'($urandom_range(1));
        exp_rdata = '0;
        x = -1; endc = 0; abort = 0;
        if (!(pat_rd[0] | pat_wr[0])) begin
            x = 1;
        end else begin
            for (int w = 0; w < MW; w++) begin
                if (1 + w >= drop_at) begin abort = 1; endc = 1 + w; break; end
                if (!(pat_rd[1 + w] | pat_wr[1 + w]) || w == MW - 1) begin x = 2 + w; break; end
            end
        end
        last = abort ? endc + 1 : x + 1;
        for (int c = 0; c <= last; c++) begin
            pi = (x >= 0 && c == x + 1 && (pat_rd[x] | pat_wr[x])) ? x : c;
            @(posedge clk); #1;
            bus.ld_req = (c < drop_at); bus.ld_wr = wr; bus.ld_addr = la; bus.ld_wdata = wdata;
            drive_cpu(pi);
            @(negedge clk);
            eg  = (c == x);
            ed  = (x >= 0 && c == x + 1);
            es  = eg && (pat_rd[pi] | pat_wr[pi]);
            erd = eg ? ~wr : pat_rd[pi];
            ewr = eg ? wr : pat_wr[pi];
            ea  = eg ? la : pat_addr[pi];
            ewd = eg ? wdata : pat_wdata[pi];
            total++;
            if ({bus.ld_gnt, bus.ld_done, bus.cpu_stall, bus.mem_rd, bus.mem_wr} !== {eg, ed, es, erd, ewr}) begin
                bad++;
                $display("FAIL ctrl cycle=%0d gnt/done/stall/rd/wr got=%b exp=%b", c,
                         {bus.ld_gnt, bus.ld_done, bus.cpu_stall, bus.mem_rd, bus.mem_wr}, {eg, ed, es, erd, ewr});
            end
            total++;
            if (bus.mem_addr !== ea) begin
                bad++; $display("FAIL mem_addr cycle=%0d got=%h exp=%h", c, bus.mem_addr, ea);
            end
            if (ewr) begin
                total++;
                if (bus.mem_wdata !== ewd) begin
                    bad++; $display("FAIL mem_wdata cycle=%0d got=%h exp=%h", c, bus.mem_wdata, ewd);
                end
            end
            total++;
            if (bus.cpu_rdata !== ref_mem[ea[9:2]]) begin
                bad++; $display("FAIL cpu_rdata cycle=%0d got=%h exp=%h", c, bus.cpu_rdata, ref_mem[ea[9:2]]);
            end
            if (ed && !wr) begin
                total++;
                if (bus.ld_rdata !== exp_rdata) begin
                    bad++; $display("FAIL ld_rdata got=%h exp=%h", bus.ld_rdata, exp_rdata);
                end
            end
            if (eg && !wr) exp_rdata = ref_mem[ea[9:2]];
            if (ewr) ref_mem[ea[9:2]] = ewd;
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        nbad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
        total++;
        if (nbad != 0) begin
            bad++; $display("FAIL memory_image words_differing got=%0d exp=0", nbad);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_idle();
        bus.cpu_rd = 1'b1; bus.cpu_addr = 32'h0000_0044; bus.cpu_wdata = $urandom;
        bus.ld_req = 1'b1; bus.ld_addr = 32'h0000_0010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.ld_gnt, bus.ld_done, bus.cpu_stall} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=000", {bus.ld_gnt, bus.ld_done, bus.cpu_stall});
        end
        total++;
        if ({bus.mem_rd, bus.mem_wr, bus.mem_addr} !== {1'b1, 1'b0, 32'h0000_0044}) begin
            bad++; $display("FAIL reset_passthru got=%b/%b/%h exp=1/0/00000044", bus.mem_rd, bus.mem_wr, bus.mem_addr);
        end
        total++;
        if (bus.ld_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_ld_rdata got=%h exp=00000000", bus.ld_rdata);
        end
        @(posedge clk); #1;
        drive_idle();
        reset = 1'b1;
    endtask

    task automatic test_idle_read();
        fill_pattern(0);
        run_transfer(1'b0, 8'd4, 32'h0, 99);
    endtask

    task automatic test_forced_write();
        fill_pattern(100);
        run_transfer(1'b1, 8'd8, 32'hDEAD_BEEF, 99);
        total++;
        if (mem[8] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL forced_write_mem got=%h exp=deadbeef", mem[8]);
        end
    endtask

    task automatic test_busy_then_idle();
        fill_pattern(0);
        for (int i = 0; i < 3; i++) begin
            pat_rd[i] = 1'b1;
            pat_addr[i] = 32'(i) << 2;
        end
        run_transfer(1'b0, 8'd12, 32'h0, 99);
    endtask

    task automatic test_drop_in_wait();
        fill_pattern(100);
        run_transfer(1'b0, 8'd3, 32'h0, 3);
        fill_pattern(100);
        run_transfer(1'b1, 8'd9, $urandom, 99);
    endtask

    task automatic test_random();
        int pcts[4] = '{0, 40, 80, 100};
        for (int n = 0; n < 24; n++) begin
            int drop;
            fill_pattern(pcts[n % 4]);
            drop = ($urandom_range(3) == 0) ? int'($urandom_range(6, 1)) : 99;
            run_transfer(1'($urandom_range(1)), 8'($urandom_range(63)), $urandom, drop);
        end
    endtask

    task automatic test_reset_in_xfer();
        logic [31:0] wd;
        fill_pattern(100);
        for (int i = 0; i < 16; i++) begin pat_rd[i] = 1'b1; pat_wr[i] = 1'b0; end
        wd = ~ref_mem[5];
        for (int c = 0; c <= MW + 1; c++) begin
            @(posedge clk); #1;
            bus.ld_req = 1'b1; bus.ld_wr = 1'b1; bus.ld_addr = 32'h0000_0014; bus.ld_wdata = wd;
            drive_cpu(c);
            if (c == MW + 1) reset = 1'b0;
        end
        @(negedge clk);
        total++;
        if (bus.ld_gnt !== 1'b1) begin
            bad++; $display("FAIL rst_xfer_gnt got=%b exp=1", bus.ld_gnt);
        end
        @(posedge clk); #1;
        reset = 1'b1; bus.ld_req = 1'b0;
        drive_cpu(MW + 2);
        @(negedge clk);
        total++;
        if ({bus.ld_gnt, bus.ld_done, bus.cpu_stall} !== 3'b000) begin
            bad++; $display("FAIL rst_xfer_ctrl got=%b exp=000", {bus.ld_gnt, bus.ld_done, bus.cpu_stall});
        end
        total++;
        if ({bus.mem_rd, bus.mem_wr, bus.mem_addr} !== {1'b1, 1'b0, pat_addr[MW + 2]}) begin
            bad++; $display("FAIL rst_xfer_passthru got=%b/%b/%h exp=1/0/%h", bus.mem_rd, bus.mem_wr, bus.mem_addr, pat_addr[MW + 2]);
        end
        total++;
        if (bus.ld_rdata !== 32'h0) begin
            bad++; $display("FAIL rst_xfer_ld_rdata got=%h exp=00000000", bus.ld_rdata);
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        total++;
        if (mem[5] !== ref_mem[5]) begin
            bad++; $display("FAIL rst_xfer_no_commit got=%h exp=%h", mem[5], ref_mem[5]);
        end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        fill_pattern(100); run_transfer(1'b0, 8'd1, 32'h0, 99);
        fill_pattern(100); run_transfer(1'b1, 8'd2, $urandom, 99);
        fill_pattern(0);   run_transfer(1'b0, 8'd3, 32'h0, 99);
        total++;
        if (stat_xfer !== 16'd3 || stat_stall !== 16'd2) begin
            bad++; $display("FAIL stats got=%0d/%0d exp=3/2", stat_xfer, stat_stall);
        end
        @(negedge clk);
        force dut.stat_stall_q = 16'hFFFE;
        #1 release dut.stat_stall_q;
        for (int n = 0; n < 2; n++) begin
            fill_pattern(100); run_transfer(1'b0, 8'd6, 32'h0, 99);
        end
        total++;
        if (stat_stall !== 16'hFFFF || stat_xfer !== 16'd5) begin
            bad++; $display("FAIL stats_sat got=%h/%0d exp=ffff/5", stat_stall, stat_xfer);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        drive_idle();
        test_reset();
        test_idle_read();
        test_forced_write();
        test_busy_then_idle();
        test_drop_in_wait();
        test_random();
        test_reset_in_xfer();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
Shares the single data-memory/peripheral bus (Data_Mem plus Peripheral, selected by addr[30]) between two masters. The CPU pipeline MEM stage has default priority. A secondary loader/debug master (UART-driven word loader) gets one-word accesses. The arbiter grants the loader in CPU idle cycles, and after a bounded wait it forces a one-cycle CPU pipeline stall.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
MAX_WAIT, 8, max cycles a pending loader request waits before forcing a stall (0 = force immediately)
WAIT_W, 4, wait-counter width; must satisfy 2^WAIT_W > MAX_WAIT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
cpu_rd  in  1  MEM-stage read request (MemRd_EX_MEM)
cpu_wr  in  1  MEM-stage write request (MemWr_EX_MEM)
cpu_addr  in  ADDR_W  MEM-stage address (ALUOut_EX_MEM)
cpu_wdata  in  DATA_W  MEM-stage write data
cpu_rdata  out  DATA_W  read data to CPU (always mem_rdata)
cpu_stall  out  1  freeze whole pipeline this cycle; CPU re-presents same access next cycle
ld_req  in  1  loader request, level, held until ld_done
ld_wr  in  1  1 = write, 0 = read; stable while ld_req
ld_addr  in  ADDR_W  loader address; stable while ld_req
ld_wdata  in  DATA_W  loader write data; stable while ld_req
ld_gnt  out  1  loader owns bus this cycle
ld_done  out  1  one-cycle completion pulse
ld_rdata  out  DATA_W  captured read data, valid while ld_done=1, held until next capture
mem_rd  out  1  bus read strobe
mem_wr  out  1  bus write strobe (committed at clk edge)
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  bus write data
mem_rdata  in  DATA_W  combinational read data from memory/peripheral mux

Behaviour:
- States: IDLE, WAIT, XFER, DONE. Reset (reset=0 at clk edge) forces IDLE, wait_cnt=0, ld_rdata=0. The outputs then resolve to ld_gnt=0, ld_done=0, cpu_stall=0, and mem_* = cpu_* passthrough.
- Bus ownership is combinational from state. XFER: mem_rd = ~ld_wr, mem_wr = ld_wr, mem_addr = ld_addr, mem_wdata = ld_wdata. All other states: mem_* = cpu_*.
- IDLE: if ld_req=1 and cpu_rd|cpu_wr=0, go to XFER. If ld_req=1 and the CPU is busy, go to WAIT with wait_cnt=0, or to XFER if MAX_WAIT=0.
- WAIT: wait_cnt increments each cycle. Go to XFER when the CPU is idle this cycle or when wait_cnt==MAX_WAIT-1. Return to IDLE (cnt cleared) if ld_req drops.
- XFER: exactly one cycle. ld_gnt=1 and cpu_stall=cpu_rd|cpu_wr. A stalled CPU access is not performed: mem_wr follows the loader only. At the clk edge, ld_rdata<=mem_rdata on a read, unchanged on a write. Next state DONE.
- DONE: ld_done=1, the CPU owns the bus, no grant is issued. Next state IDLE. A ld_req still high in IDLE is a new transaction.
- Loader throughput: at most one access per 3 cycles. CPU forced-stall rate: at most 1 cycle per MAX_WAIT+3.
- ld_req dropping during XFER or DONE is ignored; the access completes.
- A CPU that is idle in the WAIT exit cycle but busy in XFER is stalled anyway; this is correct.
- Mid-operation reset: an in-flight XFER write already on the bus commits only if the edge is not the reset edge. No ld_done is generated.
- Address decoding (RAM vs peripheral) is not the arbiter's concern; the loader may access peripheral space.

Optional Feature:
ARB_STATS_EN. When defined, add outputs stat_xfer (16 b) and stat_stall (16 b). These are saturating counts of completed loader transfers and of cycles with cpu_stall=1. Both are cleared by reset and held at 16'hFFFF on saturation. When undefined, these ports and the counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package holds: the state typedef (IDLE=2'd0, WAIT=2'd1, XFER=2'd2, DONE=2'd3), default ADDR_W/DATA_W, and the peripheral-select bit index (30).
- One natural sub-module: arb_wait_timer, holding the wait counter with clear, enable and terminal-count (==MAX_WAIT-1) output.

Test Plan:
- Loader read addr 0x00000010 with CPU idle: ld_gnt in cycle 1, mem_rd=1 with addr 0x10, ld_done in cycle 2 with ld_rdata = memory word; cpu_stall never asserted.
- CPU issues lw/sw every cycle; loader write 0xDEADBEEF to 0x20 with MAX_WAIT=8: 8 WAIT cycles, then XFER with cpu_stall=1 and mem_wr=1/addr 0x20; CPU access is re-presented and completes the next cycle; memory holds 0xDEADBEEF.
- CPU busy 3 cycles, then idle: loader enters XFER in the cycle after the first idle cycle; no stall if the CPU is idle in XFER.
- ld_req dropped in WAIT after 2 cycles: return to IDLE, no ld_gnt or ld_done; a fresh ld_req restarts wait_cnt from 0.
- reset=0 asserted during XFER of a write: next cycle state IDLE, ld_done=0, mem_* = cpu_*, ld_rdata=0.
- ARB_STATS_EN: 3 loader transfers, 2 of them forced: stat_xfer=3, stat_stall=2. Preload stat_stall near 0xFFFF: it saturates at 0xFFFF.
